aes_inv_table_seq: RTL
======================

# aes_inv_table_seq

Iterative AES decryption-round lookup unit. It accepts one 32-bit state word and produces the four inverse T-table products (InvSubBytes followed by InvMixColumns coefficients) plus the plain InvSubBytes word. The block computes the inverse S-box arithmetically, using GF(2^8) inversion by square-and-multiply, rather than from ROM. It sits in the decryption datapath as the counterpart of the forward encryption table lookup, and uses a valid/ready handshake on both sides.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a word
- state_in  input  32  bytes {b0,b1,b2,b3}, b0 = [31:24]
- out_valid  output  1  results valid
- out_ready  input  1  consumer accepts results
- p0, p1, p2, p3  output  32 each  rotated inverse T products for b0..b3
- s_out  output  32  {InvS(b0),InvS(b1),InvS(b2),InvS(b3)}
- in_key  input  32  round key word; present only with AES_DEC_KEYXOR_EN
- out_word  output  32  p0^p1^p2^p3^key; present only with AES_DEC_KEYXOR_EN

## Operation
- Four byte lanes run in parallel. Each lane has one GF(2^8) multiplier with modulus 0x11B.
- Load: each lane register x = InvAffine(b) = rotl(b,1)^rotl(b,3)^rotl(b,6)^0x05.
- Inversion computes x^254. Start with r = x.
  - Steps 0..11 alternate: even step r = r·r, odd step r = r·x. After step 11, r = x^127.
  - Step 12: r = r·r, giving x^254.
  - x = 0 yields 0 with no special case.
- s = r after step 12, so s = InvS(b).
- Td(s) = {0e·s, 09·s, 0d·s, 0b·s}, MSB first. It is computed combinationally from the lane registers with xtime chains.
- Output rotation:
  - p3 = Td(s3)
  - p2 = rotl(Td(s2),8)
  - p1 = rotr(Td(s1),16)
  - p0 = rotr(Td(s0),8)
- FSM states:
  - IDLE: in_ready = 1. On in_valid, load the lanes, step = 0, go to INV.
  - INV: one step per cycle, step increments by 1. At step 12, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. There is no queueing, and in_ready = 0 in INV and DONE.
- Outputs hold stable throughout DONE regardless of state_in and in_valid.
- Reset, asynchronous at any point including mid-INV: state = IDLE, step = 0, lane registers = 0, in_ready = 1, out_valid = 0. p*, s_out and out_word are don't-care while out_valid = 0. The in-flight word is discarded.

## Timing
- Edge E0 (handshake): load, state goes to INV.
- Edges E1..E13: steps 0..12. out_valid rises after E13, so latency is 13 cycles from the accepting edge.
- The earliest DONE→IDLE transition is at E14 when out_ready is held high. in_ready is high after E14, and the next accept is at E15.
- Maximum throughput is one word per 15 cycles.
- out_ready held low stalls in DONE indefinitely with no data change.
- out_ready while not in DONE has no effect.

## Configuration
- AES_DEC_KEYXOR_EN defined:
  - in_key is captured at E0 into a 32-bit register.
  - out_word = p0^p1^p2^p3^key_reg is valid with out_valid. This is one full decryption-round column.
- AES_DEC_KEYXOR_EN undefined: in_key, out_word and the key register do not exist. All other behaviour is identical.

## Test plan
- Reset, then state_in = 0x00000000 with out_ready = 1 -> after 13 cycles:
  - s_out = 0x52525252
  - p3 = 0x51F4A750, p0 = 0x5051F4A7, p1 = 0xA75051F4, p2 = 0xF4A75051
- state_in = 0x63637C77 -> s_out = 0x00000102, p3 = 0x1C121A16, p2 = 0x090D0B0E, p0 = p1 = 0.
- Backpressure: out_ready = 0 for 20 cycles after out_valid -> out_valid stays 1, outputs unchanged. in_ready stays 0 and a new in_valid pulse is not accepted. Releasing out_ready gives in_ready = 1 on the next cycle.
- Reset asserted at step 6 -> immediately in_ready = 1, out_valid = 0. A fresh 0x00000000 then completes correctly in 13 cycles.
- Exhaustive sweep: every byte value 0x00..0xFF placed in each byte position -> s_out matches the reference inverse S-box and p* match the Td model. Check back-to-back handshakes at 15-cycle spacing.
- With AES_DEC_KEYXOR_EN: state_in = 0, in_key = 0x01020304 -> out_word = 0x53505156.

Source files
------------

// File: rtl/aes_inv_table_seq.sv
// Iterative AES inverse T-table lookup: InvSubBytes by GF(2^8) inversion (x^254), then Td products.
// Optional macro AES_DEC_KEYXOR_EN adds the in_key register and the out_word round-column XOR.
module aes_inv_table_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] state_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p0,
    output logic [31:0] p1,
    output logic [31:0] p2,
    output logic [31:0] p3,
    output logic [31:0] s_out
`ifdef AES_DEC_KEYXOR_EN
    ,
    input  logic [31:0] in_key,
    output logic [31:0] out_word
`endif
);

    // Handshake: a word is taken on a rising edge with in_valid && in_ready; results are
    // released on a rising edge with out_valid && out_ready. Neither side queues.
    typedef enum logic [1:0] {IDLE, INV, DONE} state_e;

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] x_q [4];
    logic [7:0] x_d [4];
    logic [7:0] r_q [4];
    logic [7:0] r_d [4];
    logic [31:0] td [4];

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [31:0] td_word(input logic [7:0] s);
        logic [7:0] s2, s4, s8;
        s2 = xtime(s);
        s4 = xtime(s2);
        s8 = xtime(s4);
        return {s8 ^ s4 ^ s2, s8 ^ s, s8 ^ s4 ^ s, s8 ^ s2 ^ s};
    endfunction

`ifdef AES_DEC_KEYXOR_EN
    logic [31:0] key_q, key_d;
`endif

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        x_d       = x_q;
        r_d       = r_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef AES_DEC_KEYXOR_EN
        key_d     = key_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        x_d[i] = inv_affine(state_in[8*(3-i) +: 8]);
                        r_d[i] = inv_affine(state_in[8*(3-i) +: 8]);
                    end
`ifdef AES_DEC_KEYXOR_EN
                    key_d = in_key;
`endif
                    step_d  = 4'd0;
                    state_d = INV;
                end
            end
            INV: begin
                // Odd steps multiply by x, even steps square: r walks x^2,x^3,x^6,...,x^127,x^254.
                for (int i = 0; i < 4; i++) begin
                    r_d[i] = gf_mul(r_q[i], step_q[0] ? x_q[i] : r_q[i]);
                end
                step_d = step_q + 4'd1;
                if (step_q == 4'd12) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= 8'h00;
                r_q[i] <= 8'h00;
            end
`ifdef AES_DEC_KEYXOR_EN
            key_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            x_q     <= x_d;
            r_q     <= r_d;
`ifdef AES_DEC_KEYXOR_EN
            key_q   <= key_d;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) td[i] = td_word(r_q[i]);
    end

    assign s_out = {r_q[0], r_q[1], r_q[2], r_q[3]};
    assign p3    = td[3];
    assign p2    = {td[2][23:0], td[2][31:24]};
    assign p1    = {td[1][15:0], td[1][31:16]};
    assign p0    = {td[0][7:0],  td[0][31:8]};

`ifdef AES_DEC_KEYXOR_EN
    assign out_word = p0 ^ p1 ^ p2 ^ p3 ^ key_q;
`endif

endmodule
